// File: rtl/jtag_tap_controller_pkg.sv
// Shared TAP definitions: the 4-bit state encodings used by the controller
// and by the instruction-register decode, plus small state classifiers.
package jtag_tap_controller_pkg;

    typedef enum logic [3:0] {
        tlr_c      = 4'hF,
        rti_c      = 4'hC,
        seldr_c    = 4'h7,
        capdr_c    = 4'h6,
        shdr_c     = 4'h2,
        exit1dr_c  = 4'h1,
        pausedr_c  = 4'h3,
        exit2dr_c  = 4'h0,
        updr_c     = 4'h5,
        selir_c    = 4'h4,
        capir_c    = 4'hE,
        shir_c     = 4'hA,
        exit1ir_c  = 4'h9,
        pauseir_c  = 4'hB,
        exit2ir_c  = 4'h8,
        upir_c     = 4'hD
    } tap_state_e;

    // Capture or Shift on the IR path: the IR clock runs in these states.
    function automatic logic ir_clocking(tap_state_e s);
        return (s == capir_c) || (s == shir_c);
    endfunction

    // Capture or Shift on the DR path: the DR clock runs in these states.
    function automatic logic dr_clocking(tap_state_e s);
        return (s == capdr_c) || (s == shdr_c);
    endfunction

endpackage

// File: rtl/jtag_tap_controller_tap_fsm.sv
// 1149.1 TAP state graph: state register and next-state logic only.
// All transitions happen on rising tck; a low reset forces Test-Logic-Reset.
module jtag_tap_controller_tap_fsm
    import jtag_tap_controller_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register: reset has priority over tms.
    always_ff @(posedge tck) begin
        if (!reset) begin
            state_q <= tlr_c;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state from the standard TAP graph, steered by tms.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            tlr_c:     state_d = tms ? tlr_c     : rti_c;
            rti_c:     state_d = tms ? seldr_c   : rti_c;
            seldr_c:   state_d = tms ? selir_c   : capdr_c;
            capdr_c:   state_d = tms ? exit1dr_c : shdr_c;
            shdr_c:    state_d = tms ? exit1dr_c : shdr_c;
            exit1dr_c: state_d = tms ? updr_c    : pausedr_c;
            pausedr_c: state_d = tms ? exit2dr_c : pausedr_c;
            exit2dr_c: state_d = tms ? updr_c    : shdr_c;
            updr_c:    state_d = tms ? seldr_c   : rti_c;
            selir_c:   state_d = tms ? tlr_c     : capir_c;
            capir_c:   state_d = tms ? exit1ir_c : shir_c;
            shir_c:    state_d = tms ? exit1ir_c : shir_c;
            exit1ir_c: state_d = tms ? upir_c    : pauseir_c;
            pauseir_c: state_d = tms ? exit2ir_c : pauseir_c;
            exit2ir_c: state_d = tms ? upir_c    : shir_c;
            upir_c:    state_d = tms ? seldr_c   : rti_c;
            default:   state_d = tlr_c;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller top: the state machine plus falling-edge shift/enable/tdo
// registers, gated capture/shift clocks and active-low update strobes.
// DR chain selection is done by the instruction decode; only the already
// selected chain's serial output arrives here on dr_tdo.
module jtag_tap_controller
    import jtag_tap_controller_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    input  logic       ir_tdo,
    input  logic       dr_tdo,
    output logic [3:0] state,
    output logic       clk_ir,
    output logic       sh_ir,
    output logic       up_ir,
    output logic       clk_dr,
    output logic       sh_dr,
    output logic       up_dr,
    output logic       ir_rst_n,
    output logic       tdo,
    output logic       tdo_en
);

    tap_state_e cur_state;
    logic       en_ir;
    logic       en_dr;

    jtag_tap_controller_tap_fsm u_tap_fsm (
        .tck   (tck),
        .reset (reset),
        .tms   (tms),
        .state (cur_state)
    );

    // Falling-edge registers: enables only change while tck is low, so the
    // gated clocks below never glitch; tdo updates half a cycle after shift.
    always_ff @(negedge tck) begin
        if (!reset) begin
            sh_ir  <= 1'b0;
            sh_dr  <= 1'b0;
            en_ir  <= 1'b0;
            en_dr  <= 1'b0;
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            sh_ir  <= (cur_state == shir_c);
            sh_dr  <= (cur_state == shdr_c);
            en_ir  <= ir_clocking(cur_state);
            en_dr  <= dr_clocking(cur_state);
            tdo_en <= (cur_state == shir_c) || (cur_state == shdr_c);
            if (cur_state == shir_c) begin
                tdo <= ir_tdo;
            end else if (cur_state == shdr_c) begin
                tdo <= dr_tdo;
            end
        end
    end

    assign clk_ir   = tck & en_ir;
    assign clk_dr   = tck & en_dr;
    // Strobes are low only during the low half of the Update cycle.
    assign up_ir    = ~(~tck & (cur_state == upir_c));
    assign up_dr    = ~(~tck & (cur_state == updr_c));
    assign ir_rst_n = (cur_state != tlr_c);
    assign state    = cur_state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: abstract TAP model (path side + phase),
// a per-half-cycle compare process, directed scenarios with literal
// expectations, then a randomized tms/reset run.
module tb_jtag_tap_controller;

    logic       tck = 1'b0;
    logic       reset;
    logic       tms;
    logic       ir_tdo;
    logic       dr_tdo;
    logic [3:0] state;
    logic       clk_ir, sh_ir, up_ir, clk_dr, sh_dr, up_dr;
    logic       ir_rst_n, tdo, tdo_en;

    int n_checks = 0;
    int n_errors = 0;
    bit checks_on = 1'b0;

    jtag_tap_controller dut (
        .tck      (tck),
        .reset    (reset),
        .tms      (tms),
        .ir_tdo   (ir_tdo),
        .dr_tdo   (dr_tdo),
        .state    (state),
        .clk_ir   (clk_ir),
        .sh_ir    (sh_ir),
        .up_ir    (up_ir),
        .clk_dr   (clk_dr),
        .sh_dr    (sh_dr),
        .up_dr    (up_dr),
        .ir_rst_n (ir_rst_n),
        .tdo      (tdo),
        .tdo_en   (tdo_en)
    );

    // ---------------- clock / watchdog ----------------
    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A state is a path side (none / DR / IR) and a phase along that path.
    localparam int S_NONE = 0, S_DR = 1, S_IR = 2;
    localparam int P_TLR = 0, P_RTI = 1, P_SEL = 2, P_CAP = 3, P_SH = 4,
                   P_EX1 = 5, P_PS = 6, P_EX2 = 7, P_UP = 8;

    logic [3:0] dr_enc [0:8] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5};
    logic [3:0] ir_enc [0:8] = '{4'hF, 4'hC, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    function automatic int mk(input int s, input int ph);
        return s * 16 + ph;
    endfunction

    function automatic logic [3:0] enc(input int s, input int ph);
        return (s == S_IR) ? ir_enc[ph] : dr_enc[ph];
    endfunction

    function automatic int next_code(input int s, input int ph, input bit t);
        case (ph)
            P_TLR: return t ? mk(S_NONE, P_TLR) : mk(S_NONE, P_RTI);
            P_RTI: return t ? mk(S_DR, P_SEL) : mk(S_NONE, P_RTI);
            P_SEL: begin
                if (!t) return mk(s, P_CAP);
                return (s == S_DR) ? mk(S_IR, P_SEL) : mk(S_NONE, P_TLR);
            end
            P_CAP, P_SH: return mk(s, t ? P_EX1 : P_SH);
            P_EX1: return mk(s, t ? P_UP : P_PS);
            P_PS:  return mk(s, t ? P_EX2 : P_PS);
            P_EX2: return mk(s, t ? P_UP : P_SH);
            P_UP:  return t ? mk(S_DR, P_SEL) : mk(S_NONE, P_RTI);
            default: return mk(S_NONE, P_TLR);
        endcase
    endfunction

    int m_side = S_NONE;
    int m_ph   = P_TLR;
    bit m_sh_ir, m_sh_dr, m_en_ir, m_en_dr, m_tdo, m_tdo_en;
    int ones_run = 0;

    // Model state advance on rising tck.
    always @(posedge tck) begin
        if (!reset) begin
            m_side   <= S_NONE;
            m_ph     <= P_TLR;
            ones_run <= 5;
        end else begin
            m_side   <= next_code(m_side, m_ph, tms) / 16;
            m_ph     <= next_code(m_side, m_ph, tms) % 16;
            ones_run <= tms ? ((ones_run < 5) ? ones_run + 1 : 5) : 0;
        end
    end

    // Model falling-edge outputs.
    always @(negedge tck) begin
        if (!reset) begin
            m_sh_ir <= 1'b0; m_sh_dr <= 1'b0; m_en_ir <= 1'b0; m_en_dr <= 1'b0;
            m_tdo <= 1'b0; m_tdo_en <= 1'b0;
        end else begin
            m_sh_ir  <= (m_side == S_IR) && (m_ph == P_SH);
            m_sh_dr  <= (m_side == S_DR) && (m_ph == P_SH);
            m_en_ir  <= (m_side == S_IR) && (m_ph == P_CAP || m_ph == P_SH);
            m_en_dr  <= (m_side == S_DR) && (m_ph == P_CAP || m_ph == P_SH);
            m_tdo_en <= (m_ph == P_SH);
            if (m_ph == P_SH) m_tdo <= (m_side == S_IR) ? ir_tdo : dr_tdo;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge tck); #1;
            if (checks_on) begin
                check("state_hi", state, enc(m_side, m_ph));
                check("ir_rst_n_hi", {3'b0, ir_rst_n}, {3'b0, m_ph != P_TLR});
                check("clk_ir_hi", {3'b0, clk_ir}, {3'b0, m_en_ir});
                check("clk_dr_hi", {3'b0, clk_dr}, {3'b0, m_en_dr});
                check("up_ir_hi", {3'b0, up_ir}, 4'h1);
                check("up_dr_hi", {3'b0, up_dr}, 4'h1);
                check("tdo_hi", {3'b0, tdo}, {3'b0, m_tdo});
                check("tdo_en_hi", {3'b0, tdo_en}, {3'b0, m_tdo_en});
                if (ones_run >= 5) check("five_tms_tlr", state, 4'hF);
            end
            @(negedge tck); #1;
            if (checks_on) begin
                check("state_lo", state, enc(m_side, m_ph));
                check("up_ir_lo", {3'b0, up_ir}, {3'b0, !(m_side == S_IR && m_ph == P_UP)});
                check("up_dr_lo", {3'b0, up_dr}, {3'b0, !(m_side == S_DR && m_ph == P_UP)});
                check("clk_ir_lo", {3'b0, clk_ir}, 4'h0);
                check("clk_dr_lo", {3'b0, clk_dr}, 4'h0);
                check("sh_ir_lo", {3'b0, sh_ir}, {3'b0, m_sh_ir});
                check("sh_dr_lo", {3'b0, sh_dr}, {3'b0, m_sh_dr});
                check("tdo_lo", {3'b0, tdo}, {3'b0, m_tdo});
                check("tdo_en_lo", {3'b0, tdo_en}, {3'b0, m_tdo_en});
            end
        end
    end

    // ---------------- pulse counters ----------------
    int ir_pulses = 0, dr_pulses = 0, up_ir_lows = 0, up_dr_lows = 0;
    always @(posedge clk_ir) ir_pulses  <= ir_pulses + 1;
    always @(posedge clk_dr) dr_pulses  <= dr_pulses + 1;
    always @(negedge up_ir)  up_ir_lows <= up_ir_lows + 1;
    always @(negedge up_dr)  up_dr_lows <= up_dr_lows + 1;

    // ---------------- driver tasks ----------------
    task automatic drive(input bit t, input bit ri, input bit rd);
        tms = t; ir_tdo = ri; dr_tdo = rd;
    endtask

    task automatic half_neg();
        @(negedge tck); #1;
    endtask

    task automatic half_pos();
        @(posedge tck); #2;
    endtask

    task automatic tick(input bit t, input bit ri, input bit rd);
        drive(t, ri, rd);
        half_neg();
        half_pos();
    endtask

    task automatic tick_chk(input bit t, input logic [3:0] exp_state, input string name);
        tick(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check(name, state, exp_state);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive(0, 0, 0);

        // Reset state.
        half_pos();
        check("rst_state", state, 4'hF);
        check("rst_ir_rst_n", {3'b0, ir_rst_n}, 4'h0);
        half_neg();
        check("rst_up_ir", {3'b0, up_ir}, 4'h1);
        check("rst_tdo_en", {3'b0, tdo_en}, 4'h0);
        check("rst_sh_ir", {3'b0, sh_ir}, 4'h0);
        checks_on = 1'b1;
        reset = 1'b1;
        half_pos();
        check("first_rti", state, 4'hC);

        // RTI -> Shift-IR with one capture clock.
        ir_pulses = 0;
        tick_chk(1, 4'h7, "to_seldr");
        tick_chk(1, 4'h4, "to_selir");
        tick_chk(0, 4'hE, "to_capir");
        tick_chk(0, 4'hA, "to_shir");
        check("capir_pulse", 4'(ir_pulses), 4'd1);

        // Shift 1,0,1 out of the IR, then update.
        up_ir_lows = 0;
        drive(0, 1, 0); half_neg();
        check("shir_sh", {3'b0, sh_ir}, 4'h1);
        check("shir_bit0", {3'b0, tdo}, 4'h1);
        half_pos();
        drive(0, 0, 0); half_neg();
        check("shir_bit1", {3'b0, tdo}, 4'h0);
        half_pos();
        drive(1, 1, 0); half_neg();
        check("shir_bit2", {3'b0, tdo}, 4'h1);
        half_pos();
        check("to_ex1ir", state, 4'h9);
        drive(1, 0, 0); half_neg();
        check("ex1ir_tdo_hold", {3'b0, tdo}, 4'h1);
        check("ex1ir_tdo_en", {3'b0, tdo_en}, 4'h0);
        half_pos();
        check("to_upir", state, 4'hD);
        drive(0, 0, 0); half_neg();
        check("upir_strobe", {3'b0, up_ir}, 4'h0);
        half_pos();
        check("upir_to_rti", state, 4'hC);
        check("upir_lows", 4'(up_ir_lows), 4'd1);
        check("ir_pulse_total", 4'(ir_pulses), 4'd4);

        // DR pause / resume.
        tick_chk(1, 4'h7, "dr_seldr");
        tick_chk(0, 4'h6, "dr_capdr");
        tick_chk(0, 4'h2, "dr_shdr");
        tick_chk(1, 4'h1, "dr_ex1");
        dr_pulses = 0;
        drive(0, 0, 1); half_neg();
        check("ex1dr_tdo_en", {3'b0, tdo_en}, 4'h0);
        half_pos();
        check("dr_pause", state, 4'h3);
        drive(0, 0, 1); half_neg();
        check("pausedr_tdo_en", {3'b0, tdo_en}, 4'h0);
        half_pos();
        check("dr_pause2", state, 4'h3);
        tick_chk(1, 4'h0, "dr_ex2");
        tick_chk(0, 4'h2, "dr_resume");
        check("dr_pause_no_clk", 4'(dr_pulses), 4'd0);
        tick_chk(1, 4'h1, "dr_ex1b");
        tick_chk(1, 4'h5, "dr_update");
        tick_chk(0, 4'hC, "dr_rti");

        // Shift-IR -> TLR with five tms=1, passing through Update-IR.
        tick_chk(1, 4'h7, "b_seldr");
        tick_chk(1, 4'h4, "b_selir");
        tick_chk(0, 4'hE, "b_capir");
        tick_chk(0, 4'hA, "b_shir");
        up_ir_lows = 0;
        tick_chk(1, 4'h9, "b_ex1ir");
        tick_chk(1, 4'hD, "b_upir");
        tick_chk(1, 4'h7, "b_seldr2");
        tick_chk(1, 4'h4, "b_selir2");
        tick_chk(1, 4'hF, "b_tlr");
        check("b_up_ir_once", 4'(up_ir_lows), 4'd1);
        check("b_ir_rst_n", {3'b0, ir_rst_n}, 4'h0);

        // Reset in the middle of Shift-DR.
        tick_chk(0, 4'hC, "c_rti");
        tick_chk(1, 4'h7, "c_seldr");
        tick_chk(0, 4'h6, "c_capdr");
        tick_chk(0, 4'h2, "c_shdr");
        up_dr_lows = 0;
        drive(0, 0, 1); half_neg();
        reset = 1'b0;
        half_pos();
        check("c_reset_tlr", state, 4'hF);
        half_neg();
        check("c_sh_dr", {3'b0, sh_dr}, 4'h0);
        check("c_tdo_en", {3'b0, tdo_en}, 4'h0);
        reset = 1'b1;
        half_pos();
        tick_chk(0, 4'hC, "c_rti2");
        check("c_no_up_dr", 4'(up_dr_lows), 4'd0);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            half_neg();
            half_pos();
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick(1, 0, 0);
        check("final_tlr", state, 4'hF);

        half_neg();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
